sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
Serial pattern transmitter, the counterpart of the team's serial sequence detector. It loads a WIDTH-bit pattern on a start handshake and shifts it out MSB-first, one bit per clock. The frame is repeated a programmable number of times, with GAP_CYCLES idle zeros between frames. Its out/register pins mirror the detector's in/register pins, so the two connect back-to-back in loopback benches.

Parameters:
WIDTH, 6, pattern length in bits (>=2)
GAP_CYCLES, 2, idle cycles between consecutive frames (0 = back-to-back frames)
CNT_W, 4, width of the repeat count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to transmit; sampled only in IDLE
pattern  input  WIDTH  frame to send, latched when start is accepted
repeat_cnt  input  CNT_W  number of frames to send, latched with pattern
out  output  1  serial data, registered
out_valid  output  1  high while out carries a pattern bit, registered
busy  output  1  high from first bit through last bit of last frame
done  output  1  one-cycle pulse after the last bit (or immediately if repeat_cnt==0)
register  output  WIDTH  current shift-register contents, for debug and loopback comparison

Behaviour:
- Reset (sync, active-high, highest priority, also mid-operation):
  - state=IDLE; out=0, out_valid=0, busy=0, done=0, register=0; internal counters=0.
  - A frame in flight is aborted; no done pulse is produced.
- States: IDLE, SEND, GAP, DONE. Encoding is 2 bits, defined in the package.
- IDLE, start=1 at edge E0:
  - latch pattern into pat_q and into register; latch reps=repeat_cnt.
  - if repeat_cnt==0: go to DONE; out_valid stays 0.
  - else go to SEND; after E0, out=pattern[WIDTH-1], out_valid=1, busy=1, bit index=WIDTH-1.
- SEND, each edge:
  - register shifts left with 0 fill; out takes the next bit.
  - Frame bit k (MSB=0) is visible after edge E0+k.
  - After the edge that drives the last bit, the next edge acts as follows:
    - reps-1>0 and GAP_CYCLES>0: go to GAP; out=0, out_valid=0, busy stays 1.
    - reps-1>0 and GAP_CYCLES==0: reload register from pat_q; out=pat_q[WIDTH-1], out_valid=1 (no bubble).
    - reps-1==0: go to DONE; out=0, out_valid=0, busy=0, done=1.
- GAP: hold out=0, out_valid=0 for exactly GAP_CYCLES cycles, then reload from pat_q and enter SEND as above.
- DONE: done=1 for exactly one cycle, then IDLE. start is not accepted in DONE.
- start, pattern and repeat_cnt are ignored outside IDLE; a later change to the inputs does not alter the frame in flight.
- Latency: first bit 1 cycle after start is accepted.
  - Total busy cycles = reps*WIDTH + (reps-1)*GAP_CYCLES.
  - done is asserted in the cycle after busy falls.
- Arithmetic: the repeat counter decrements without wrap. The max of 2^CNT_W-1 frames must be supported.

Decomposition:
- Package seq_pkg:
  - state localparams IDLE=0, SEND=1, GAP=2, DONE=3;
  - default WIDTH, GAP_CYCLES, CNT_W;
  - a shared constant for the demo pattern 6'b101011, so generator and detector benches use the same value.
- One sub-module, seq_piso: parallel-in/serial-out shift register with load, shift and sync clear. It drives out and register.
- The FSM and the bit, gap and repeat counters stay in sequence_generator.

Test Plan:
1. Single frame: reset 2 cycles; start with pattern=6'b101011, repeat_cnt=1 -> out=1,0,1,0,1,1 on cycles 1..6 with out_valid=1; busy high 6 cycles; done pulse on cycle 7; back to IDLE.
2. Repeats with gap: pattern=6'b110010, repeat_cnt=3, GAP_CYCLES=2 -> three frames with 2 zero/out_valid=0 cycles between; busy for 22 cycles; exactly one done pulse.
3. Zero repeats: repeat_cnt=0 -> done on cycle 1; out_valid and busy never rise.
4. Start while busy: reassert start with a different pattern at cycle 3 -> ignored; the original bitstream and timing are unchanged.
5. Reset mid-frame: assert reset at the 4th bit -> the next cycle shows out=0, out_valid=0, busy=0, register=0, no done; a subsequent start works normally.
6. Loopback: out drives the detector's in with pattern 6'b101011, repeat_cnt=4, GAP_CYCLES=0 -> the detector's out pulses once per completed frame (4 pulses), and the detector register matches the generator's pat_q after each frame.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator and its companion
// sequence detector.
//   - Default geometry: pattern width, inter-frame gap length, repeat
//     counter width.
//   - FSM state encoding (2 bits).
//   - DEMO_PATTERN: a common demo frame, so generator and detector benches
//     exercise the same bits.
package seq_pkg;

  localparam int WIDTH_DEF      = 6;
  localparam int GAP_CYCLES_DEF = 2;
  localparam int CNT_W_DEF      = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t SEND = 2'd1;
  localparam state_t GAP  = 2'd2;
  localparam state_t DONE = 2'd3;

  localparam logic [5:0] DEMO_PATTERN = 6'b101011;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in / serial-out shift register. Bits leave from the MSB end.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset (clears everything)
//   clear_i    - synchronous clear of the shift register
//   load_i     - load data_i into the shift register
//   shift_i    - shift left by one, zero fill
//   emit_i     - serial output may carry the new MSB; otherwise it is forced to 0
//   data_i     - parallel load value
//   out_o      - registered serial bit (MSB of the updated register when emitting)
//   register_o - current shift-register contents
//
// Priority of the controls: clear, then load, then shift.
module seq_piso #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             emit_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             out_o,
  output logic [WIDTH-1:0] register_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             out_q;

  always_comb begin
    shreg_d = shreg_q;
    if (clear_i) begin
      shreg_d = '0;
    end else if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // The serial bit is a separate flop so it can stay at 0 while the
  // register holds a freshly loaded frame that is not being transmitted.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      out_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      out_q   <= emit_i & shreg_d[WIDTH-1];
    end
  end

  assign out_o      = out_q;
  assign register_o = shreg_q;

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter.
//   - A WIDTH-bit pattern is latched on start (accepted in IDLE only).
//   - Each frame is shifted out MSB-first, one bit per clock.
//   - The frame is repeated repeat_cnt times, with GAP_CYCLES idle zeros
//     between consecutive frames.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset, highest priority
//   start      - transmit request, sampled only in IDLE
//   pattern    - frame to send, latched when start is accepted
//   repeat_cnt - number of frames, latched with pattern (0 = done immediately)
//   out        - registered serial data
//   out_valid  - registered, high while out carries a pattern bit
//   busy       - high from the first bit through the last bit of the last frame
//   done       - one-cycle pulse after the last bit
//   register   - current shift-register contents
module sequence_generator
  import seq_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] register
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST =
      (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] ONE_REP = CNT_W'(1);

  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;     // bits left in the current frame, minus one
  logic [GAP_W-1:0] gap_q, gap_d;     // idle cycles left in the gap, minus one
  logic [CNT_W-1:0] reps_q, reps_d;   // frames left, including the current one
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             piso_load;
  logic             piso_shift;
  logic             piso_clear;
  logic             piso_emit;
  logic [WIDTH-1:0] piso_data;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (repeat_cnt == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (bit_q == '0) begin
          if (reps_q > ONE_REP) begin
            state_d = (GAP_CYCLES > 0) ? GAP : SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = SEND;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath control.
  // Every output is registered, so this block computes the values that
  // become visible after the coming edge.
  always_comb begin
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_clear = 1'b0;
    piso_emit  = 1'b0;
    piso_data  = pat_q;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    bit_d      = bit_q;
    gap_d      = gap_q;
    reps_d     = reps_q;
    pat_d      = pat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d     = pattern;
          reps_d    = repeat_cnt;
          piso_load = 1'b1;
          piso_data = pattern;
          bit_d     = BIT_LAST;
          if (repeat_cnt != '0) begin
            piso_emit = 1'b1;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (bit_q != '0) begin
          piso_shift = 1'b1;
          piso_emit  = 1'b1;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          bit_d      = bit_q - BIT_W'(1);
        end else if (reps_q > ONE_REP) begin
          reps_d = reps_q - ONE_REP;
          busy_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            // The extra shift empties the register, so out reads 0 in the gap.
            piso_shift = 1'b1;
            gap_d      = GAP_LAST;
          end else begin
            // Back-to-back frames: reload with no bubble.
            piso_load = 1'b1;
            piso_emit = 1'b1;
            valid_d   = 1'b1;
            bit_d     = BIT_LAST;
          end
        end else begin
          piso_shift = 1'b1;
          reps_d     = '0;
          done_d     = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0) begin
          piso_load = 1'b1;
          piso_emit = 1'b1;
          valid_d   = 1'b1;
          bit_d     = BIT_LAST;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      DONE: begin
        piso_clear = 1'b1;
      end
      default: begin
        piso_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_q   <= '0;
      gap_q   <= '0;
      reps_q  <= '0;
      pat_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      reps_q  <= reps_d;
      pat_q   <= pat_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  seq_piso #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (piso_clear),
    .load_i    (piso_load),
    .shift_i   (piso_shift),
    .emit_i    (piso_emit),
    .data_i    (piso_data),
    .out_o     (out),
    .register_o(register)
  );

  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
module tb_sequence_generator;
  import seq_pkg::*;

  localparam int W  = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_a, start_b;
  logic [W-1:0]  pat_in;
  logic [CW-1:0] rep_in;

  logic          out_a, valid_a, busy_a, done_a;
  logic [W-1:0]  reg_a;
  logic          out_b, valid_b, busy_b, done_b;
  logic [W-1:0]  reg_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instance A: default gap of 2 cycles.
  sequence_generator #(.WIDTH(W), .GAP_CYCLES(2), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pattern(pat_in),
    .repeat_cnt(rep_in), .out(out_a), .out_valid(valid_a), .busy(busy_a),
    .done(done_a), .register(reg_a)
  );

  // Instance B: back-to-back frames, used for the loopback run.
  sequence_generator #(.WIDTH(W), .GAP_CYCLES(0), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pattern(pat_in),
    .repeat_cnt(rep_in), .out(out_b), .out_valid(valid_b), .busy(busy_b),
    .done(done_b), .register(reg_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one transmission and checks every cycle against the waveform
  // implied by pattern/reps/gap. disturb_at > 0 re-asserts start with
  // different inputs at that cycle. The loopback receiver runs only for
  // instance B.
  task automatic run_stream(input string name, input logic [W-1:0] pat,
                            input int reps, input int gap, input int use_b,
                            input int disturb_at);
    int total, len, idx, p, nvalid, frames;
    logic ev, eo, eb, ed, ov, oo, ob, od;
    logic [W-1:0] er, orr, det;
    total  = (reps == 0) ? 0 : reps * W + (reps - 1) * gap;
    len    = W + gap;
    nvalid = 0;
    frames = 0;
    det    = '0;
    pat_in = pat;
    rep_in = CW'(reps);
    if (use_b != 0) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 1; c <= total + 2; c++) begin
      idx = c - 1;
      ev = 1'b0; eo = 1'b0; eb = 1'b0; ed = 1'b0; er = '0;
      if (idx < total) begin
        eb = 1'b1;
        p  = idx % len;
        if (p < W) begin
          ev = 1'b1;
          eo = pat[W-1-p];
          er = pat << p;
        end
      end else if (idx == total) begin
        ed = 1'b1;
      end
      ov  = (use_b != 0) ? valid_b : valid_a;
      oo  = (use_b != 0) ? out_b   : out_a;
      ob  = (use_b != 0) ? busy_b  : busy_a;
      od  = (use_b != 0) ? done_b  : done_a;
      orr = (use_b != 0) ? reg_b   : reg_a;
      check($sformatf("%s c%0d out", name, c), 32'(oo), 32'(eo));
      check($sformatf("%s c%0d out_valid", name, c), 32'(ov), 32'(ev));
      check($sformatf("%s c%0d busy", name, c), 32'(ob), 32'(eb));
      check($sformatf("%s c%0d done", name, c), 32'(od), 32'(ed));
      if (ev) check($sformatf("%s c%0d register", name, c), 32'(orr), 32'(er));
      if (use_b != 0 && ov) begin
        det = {det[W-2:0], oo};
        nvalid++;
        if (nvalid % W == 0) begin
          frames++;
          check($sformatf("%s frame%0d det_reg", name, frames), 32'(det), 32'(pat));
        end
      end
      if (c == disturb_at) begin
        if (use_b != 0) start_b = 1'b1; else start_a = 1'b1;
        pat_in = ~pat;
        rep_in = 4'd9;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      tick();
    end
    start_a = 1'b0;
    start_b = 1'b0;
    if (use_b != 0) check($sformatf("%s det_pulses", name), 32'(frames), 32'(reps));
    $display("%s: pattern=%b reps=%0d gap=%0d busy_cycles=%0d", name, pat, reps, gap, total);
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    pat_in  = '0;
    rep_in  = '0;
    tick();
    tick();
    check("reset out", 32'(out_a), 32'd0);
    check("reset out_valid", 32'(valid_a), 32'd0);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset done", 32'(done_a), 32'd0);
    check("reset register", 32'(reg_a), 32'd0);
    check("reset b busy", 32'(busy_b), 32'd0);
    $display("reset: 2 cycles applied");
    reset = 1'b0;
    tick();

    run_stream("single", DEMO_PATTERN, 1, 2, 0, 0);
    run_stream("gap3", 6'b110010, 3, 2, 0, 0);
    run_stream("zero", 6'b111111, 0, 2, 0, 0);
    run_stream("busy_start", 6'b100110, 2, 2, 0, 3);

    // Reset while the 4th bit of a frame is on the wire.
    pat_in  = DEMO_PATTERN;
    rep_in  = 4'd1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    tick();
    check("midrst bit4 out", 32'(out_a), 32'(DEMO_PATTERN[2]));
    check("midrst bit4 busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst out", 32'(out_a), 32'd0);
    check("midrst out_valid", 32'(valid_a), 32'd0);
    check("midrst busy", 32'(busy_a), 32'd0);
    check("midrst done", 32'(done_a), 32'd0);
    check("midrst register", 32'(reg_a), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("midrst post%0d done", i), 32'(done_a), 32'd0);
      check($sformatf("midrst post%0d busy", i), 32'(busy_a), 32'd0);
    end
    $display("midrst: reset at bit 4, no done afterwards");

    run_stream("after_rst", 6'b010111, 1, 2, 0, 0);
    run_stream("max_reps", 6'b011101, 15, 2, 0, 0);
    run_stream("loopback", DEMO_PATTERN, 4, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
